// File: rtl/alu_cmd_driver.sv
// Command-side initiator for an 8-bit combinational ALU.
// Accepts a command, registers opcode and operands into the ALU, and waits a
// fixed settle time. It then captures the result into the response register
// and the accumulator, and holds the response until the consumer takes it.
module alu_cmd_driver #(
    parameter int WIDTH  = 8,
    parameter int OPW    = 3,
    parameter int SETTLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [OPW-1:0]   cmd_op_i,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    input  logic             cmd_use_acc_i,
    output logic [OPW-1:0]   alu_opcode_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_illegal_o,
    output logic [WIDTH-1:0] acc_o
);

    // state | meaning
    // IDLE  | ready for a command
    // WAIT  | ALU inputs applied, counting down the settle time
    // RESP  | response held until the consumer accepts it
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    localparam logic [3:0]     CNT_INIT = 4'(SETTLE - 1);
    localparam logic [OPW-1:0] OP_LAST  = OPW'(4);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_illegal_q, rsp_illegal_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             op_legal;

    assign op_legal = (op_q <= OP_LAST);

    // Ready depends on state only; it is forced low while reset is asserted.
    assign cmd_ready_o = (state_q == ST_IDLE) && rst_n_i;

    // Next-state logic: accept, count down the settle time, capture, and hand off.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_illegal_d = rsp_illegal_q;
        acc_d         = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    a_d     = cmd_use_acc_i ? acc_q : cmd_a_i;
                    b_d     = cmd_b_i;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (op_legal) begin
                        rsp_data_d    = alu_result_i;
                        rsp_illegal_d = 1'b0;
                        acc_d         = alu_result_i;
                    end else begin
                        rsp_data_d    = '0;
                        rsp_illegal_d = 1'b1;
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_illegal_q <= 1'b0;
            acc_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_illegal_q <= rsp_illegal_d;
            acc_q         <= acc_d;
        end
    end

    assign alu_opcode_o  = op_q;
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_illegal_o = rsp_illegal_q;
    assign acc_o         = acc_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: two instances (SETTLE=1 and SETTLE=3), each driving its own ALU.
module tb_alu_cmd_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         sel = 0;
    logic       cmd_valid = 1'b0;
    logic       rsp_ready = 1'b1;
    logic [2:0] cmd_op = '0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic       cmd_use_acc = 1'b0;

    logic       cv [2];
    logic       rr [2];
    logic       crdy [2];
    logic [2:0] aop [2];
    logic [7:0] aa [2], ab [2], ares [2], rdat [2], accv [2];
    logic       rv [2], ril [2];

    logic       o_crdy, o_rv, o_ril;
    logic [2:0] o_aop;
    logic [7:0] o_aa, o_ab, o_rdat, o_acc;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] acc_m [2];
    int         settle_m [2];

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    alu_fn = a + b;
            3'd1:    alu_fn = a - b;
            3'd2:    alu_fn = a & b;
            3'd3:    alu_fn = a | b;
            3'd4:    alu_fn = ~a;
            default: alu_fn = 8'hA5;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ares[i] = alu_fn(aop[i], aa[i], ab[i]);
            cv[i]   = cmd_valid && (sel == i);
            rr[i]   = (sel == i) ? rsp_ready : 1'b1;
        end
    end

    always_comb begin
        o_crdy = crdy[sel];
        o_rv   = rv[sel];
        o_ril  = ril[sel];
        o_aop  = aop[sel];
        o_aa   = aa[sel];
        o_ab   = ab[sel];
        o_rdat = rdat[sel];
        o_acc  = accv[sel];
    end

    alu_cmd_driver #(.WIDTH(8), .OPW(3), .SETTLE(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cv[0]), .cmd_ready_o(crdy[0]), .cmd_op_i(cmd_op),
        .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_use_acc_i(cmd_use_acc),
        .alu_opcode_o(aop[0]), .alu_a_o(aa[0]), .alu_b_o(ab[0]), .alu_result_i(ares[0]),
        .rsp_valid_o(rv[0]), .rsp_ready_i(rr[0]), .rsp_data_o(rdat[0]),
        .rsp_illegal_o(ril[0]), .acc_o(accv[0])
    );

    alu_cmd_driver #(.WIDTH(8), .OPW(3), .SETTLE(3)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cv[1]), .cmd_ready_o(crdy[1]), .cmd_op_i(cmd_op),
        .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_use_acc_i(cmd_use_acc),
        .alu_opcode_o(aop[1]), .alu_a_o(aa[1]), .alu_b_o(ab[1]), .alu_result_i(ares[1]),
        .rsp_valid_o(rv[1]), .rsp_ready_i(rr[1]), .rsp_data_o(rdat[1]),
        .rsp_illegal_o(ril[1]), .acc_o(accv[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (dut%0d) got=0x%0h exp=0x%0h at %0t", tag, sel, got, exp, $time);
        end
    endtask

    // Reference result computed directly from the opcode definitions, modulo 256.
    function automatic int ref_result(input int op, input int a, input int b, output bit illegal);
        illegal = 1'b0;
        case (op)
            0:       ref_result = (a + b) % 256;
            1:       ref_result = (a - b + 256) % 256;
            2:       ref_result = a & b;
            3:       ref_result = a | b;
            4:       ref_result = 255 - a;
            default: begin ref_result = 0; illegal = 1'b1; end
        endcase
    endfunction

    // One full transaction on the selected instance, starting and ending at a negedge.
    task automatic do_cmd(input int op, input int a, input int b, input bit ua, input int stall);
        int  n;
        int  ea, er;
        bit  eil;
        n = 0;
        while (!o_crdy && n < 20) begin @(negedge clk); n++; end
        chk("cmd_ready_idle", 32'(o_crdy), 32'd1);
        ea = ua ? int'(acc_m[sel]) : a;
        er = ref_result(op, ea, b, eil);
        cmd_op = 3'(op); cmd_a = 8'(a); cmd_b = 8'(b); cmd_use_acc = ua;
        cmd_valid = 1'b1;
        rsp_ready = (stall == 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        chk("alu_opcode", 32'(o_aop), 32'(op));
        chk("alu_a", 32'(o_aa), 32'(ea));
        chk("alu_b", 32'(o_ab), 32'(b));
        chk("cmd_ready_busy", 32'(o_crdy), 32'd0);
        n = 0;
        while (!o_rv && n < 40) begin @(negedge clk); n++; end
        chk("latency", 32'(n), 32'(settle_m[sel]));
        chk("rsp_data", 32'(o_rdat), 32'(er));
        chk("rsp_illegal", 32'(o_ril), 32'(eil));
        if (!eil) acc_m[sel] = 8'(er);
        chk("acc", 32'(o_acc), 32'(acc_m[sel]));
        for (int i = 0; i < stall; i++) begin
            cmd_valid = 1'b1;
            cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
            @(negedge clk);
            chk("stall_rsp_valid", 32'(o_rv), 32'd1);
            chk("stall_rsp_data", 32'(o_rdat), 32'(er));
            chk("stall_cmd_ready", 32'(o_crdy), 32'd0);
            chk("stall_alu_a", 32'(o_aa), 32'(ea));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_valid_clr", 32'(o_rv), 32'd0);
        chk("cmd_ready_back", 32'(o_crdy), 32'd1);
        chk("rsp_data_hold", 32'(o_rdat), 32'(er));
        chk("acc_hold", 32'(o_acc), 32'(acc_m[sel]));
    endtask

    initial begin
        acc_m[0] = '0; acc_m[1] = '0;
        settle_m[0] = 1; settle_m[1] = 3;

        #3;
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #0;
            chk("rst_cmd_ready", 32'(o_crdy), 32'd0);
            chk("rst_rsp_valid", 32'(o_rv), 32'd0);
            chk("rst_rsp_data", 32'(o_rdat), 32'd0);
            chk("rst_acc", 32'(o_acc), 32'd0);
            chk("rst_alu", {o_aop, o_aa, o_ab}, 32'd0);
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_cmd(0, 8'h0A, 8'h05, 1'b0, 0);
        do_cmd(1, 8'h05, 8'h0A, 1'b0, 0);
        do_cmd(0, 8'h00, 8'h07, 1'b1, 0);
        do_cmd(2, 8'hF0, 8'h3C, 1'b0, 0);
        do_cmd(3, 8'hF0, 8'h0F, 1'b0, 0);
        do_cmd(4, 8'h0A, 8'h00, 1'b0, 0);
        do_cmd(0, 8'h0A, 8'h05, 1'b0, 0);
        do_cmd(5, 8'h11, 8'h22, 1'b0, 0);
        do_cmd(7, 8'h33, 8'h44, 1'b1, 0);
        do_cmd(0, 8'h01, 8'h01, 1'b1, 5);

        for (int k = 0; k < 40; k++)
            do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));

        sel = 1;
        @(negedge clk);
        do_cmd(0, 8'h0A, 8'h05, 1'b0, 0);
        do_cmd(1, 8'h00, 8'h01, 1'b1, 2);
        for (int k = 0; k < 15; k++)
            do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));

        // Abort a command in WAIT with a reset pulse.
        cmd_op = 3'd0; cmd_a = 8'h20; cmd_b = 8'h01; cmd_use_acc = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("wait_no_rsp", 32'(o_rv), 32'd0);
        rst_n = 1'b0;
        #1;
        acc_m[0] = '0; acc_m[1] = '0;
        chk("abort_cmd_ready", 32'(o_crdy), 32'd0);
        chk("abort_rsp_valid", 32'(o_rv), 32'd0);
        chk("abort_acc", 32'(o_acc), 32'd0);
        chk("abort_alu", {o_aop, o_aa, o_ab}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_abort_rsp_valid", 32'(o_rv), 32'd0);
            chk("post_abort_cmd_ready", 32'(o_crdy), 32'd1);
        end
        do_cmd(0, 8'hFF, 8'h05, 1'b1, 0);
        sel = 0;
        #0;
        do_cmd(0, 8'hFF, 8'h09, 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout got=running exp=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
